// File: rtl/fp_addsub_if.sv
// Operand/result handshake bundle for fp_addsub_pipe.
//   master : the producer/consumer side (drives operands and out_ready)
//   slave  : the adder side (drives in_ready, out_valid, result, flags)
// Signals:
//   in_valid/in_ready   operand handshake; a, b, sub are the operands
//   out_valid/out_ready result handshake; result, flags are the outputs
//   flags = {invalid, overflow, underflow, inexact}
interface fp_addsub_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) ();
  localparam int W = 1 + EXP_W + MAN_W;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic [3:0]   flags;

  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, result, flags
  );

  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, result, flags
  );
endinterface

// File: rtl/fp_addsub_pipe.sv
// 3-stage pipelined floating-point adder/subtractor (round-to-nearest-even,
// flush-to-zero for subnormal inputs and outputs).
//   S1 align : classify, swap so |X|>=|Y|, shift Y right with guard/round/sticky
//   S2 add   : add or subtract the aligned significands
//   S3 round : normalise, round, pack, select special/exception results
// Ports:
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus        : fp_addsub_if.slave (operand and result valid/ready handshakes)
// The whole pipe advances when the output register is empty or being drained,
// so in_ready is simply that enable.
module fp_addsub_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input logic         clk,
  input logic         rst_n,
  fp_addsub_if.slave  bus
);
  localparam int W       = 1 + EXP_W + MAN_W;
  localparam int AW      = MAN_W + 4;          // hidden, mantissa, G, R, S
  localparam int SW      = MAN_W + 5;          // AW plus carry-out
  localparam int LZW     = $clog2(SW);
  localparam int EW2     = EXP_W + 2;          // signed exponent headroom
  localparam int EXP_MAX = (1 << EXP_W) - 1;
  localparam logic [W-1:0]   QNAN    = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
  localparam logic [W-2:0]   INF_MAG = {{EXP_W{1'b1}}, {MAN_W{1'b0}}};

  logic en;
  assign en           = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = en;

  // ---------------- S1: classify and align ----------------
  logic             sa, sb, sx, sy, hx, hy;
  logic [EXP_W-1:0] ea, eb, ex, ey, d;
  logic [MAN_W-1:0] maf, mbf, mxf, myf;
  logic             a_zero, b_zero, a_nan, b_nan, a_inf, b_inf;
  logic [AW-1:0]    mx_al, my_al, y_ext, y_sh, lost_mask;
  logic             sp_c;
  logic [W-1:0]     sp_res_c;
  logic [3:0]       sp_flags_c;

  // NOTE: combinational blocks use blocking '=' and give every output a
  // default before any branch so no latch is inferred; clocked blocks use '<='.
  always_comb begin
    sa     = bus.a[W-1];
    sb     = bus.b[W-1] ^ bus.sub;            // subtraction = add with B negated
    ea     = bus.a[W-2:MAN_W];
    eb     = bus.b[W-2:MAN_W];
    a_zero = (ea == '0);
    b_zero = (eb == '0);
    a_nan  = (ea == '1) && (bus.a[MAN_W-1:0] != '0);
    b_nan  = (eb == '1) && (bus.b[MAN_W-1:0] != '0);
    a_inf  = (ea == '1) && (bus.a[MAN_W-1:0] == '0);
    b_inf  = (eb == '1) && (bus.b[MAN_W-1:0] == '0);
    // Subnormals become signed zero: their fraction is dropped.
    maf    = a_zero ? '0 : bus.a[MAN_W-1:0];
    mbf    = b_zero ? '0 : bus.b[MAN_W-1:0];

    if ({ea, maf} >= {eb, mbf}) begin
      sx = sa; ex = ea; mxf = maf; hx = !a_zero;
      sy = sb; ey = eb; myf = mbf; hy = !b_zero;
    end else begin
      sx = sb; ex = eb; mxf = mbf; hx = !b_zero;
      sy = sa; ey = ea; myf = maf; hy = !a_zero;
    end

    d         = ex - ey;
    mx_al     = {hx, mxf, 3'b000};
    y_ext     = {hy, myf, 3'b000};
    y_sh      = y_ext >> d;
    // Everything shifted out collapses into the sticky bit; a shift past the
    // whole field leaves only sticky.
    lost_mask = ~({AW{1'b1}} << d);
    my_al     = {y_sh[AW-1:1], y_sh[0] | (|(y_ext & lost_mask))};

    sp_c       = 1'b1;
    sp_res_c   = '0;
    sp_flags_c = '0;
    if (a_nan || b_nan) begin
      sp_res_c   = QNAN;
      sp_flags_c = 4'b1000;
    end else if (a_inf && b_inf) begin
      if (sa != sb) begin
        sp_res_c   = QNAN;
        sp_flags_c = 4'b1000;
      end else begin
        sp_res_c   = {sa, INF_MAG};
      end
    end else if (a_inf) begin
      sp_res_c = {sa, INF_MAG};
    end else if (b_inf) begin
      sp_res_c = {sb, INF_MAG};
    end else if (a_zero && b_zero) begin
      sp_res_c = {sa & sb, {(W-1){1'b0}}};     // -0 only when both are -0
    end else begin
      sp_c = 1'b0;
    end
  end

  // ---------------- stage registers ----------------
  logic             s1_valid, s2_valid;
  logic             s1_sign, s1_eff_sub, s1_sp, s2_sign, s2_sp;
  logic [EXP_W-1:0] s1_exp, s2_exp;
  logic [AW-1:0]    s1_mx, s1_my;
  logic [SW-1:0]    s2_sum;
  logic [W-1:0]     s1_sp_res, s2_sp_res, res_c;
  logic [3:0]       s1_sp_flags, s2_sp_flags, flags_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid      <= 1'b0;
      s2_valid      <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.result    <= '0;
      bus.flags     <= '0;
    end else if (en) begin
      s1_valid      <= bus.in_valid;
      s2_valid      <= s1_valid;
      bus.out_valid <= s2_valid;
      if (s2_valid) begin
        bus.result <= res_c;
        bus.flags  <= flags_c;
      end
    end
  end

  // NOTE: the datapath registers carry no reset; they are only ever observed
  // behind a valid bit, which is reset.
  always_ff @(posedge clk) begin
    if (en && bus.in_valid) begin
      s1_sign     <= sx;
      s1_exp      <= ex;
      s1_mx       <= mx_al;
      s1_my       <= my_al;
      s1_eff_sub  <= sx ^ sy;
      s1_sp       <= sp_c;
      s1_sp_res   <= sp_res_c;
      s1_sp_flags <= sp_flags_c;
    end
    if (en && s1_valid) begin
      s2_sign     <= s1_sign;
      s2_exp      <= s1_exp;
      // The swap guarantees X >= Y, so the difference is never negative.
      s2_sum      <= s1_eff_sub ? ({1'b0, s1_mx} - {1'b0, s1_my})
                                : ({1'b0, s1_mx} + {1'b0, s1_my});
      s2_sp       <= s1_sp;
      s2_sp_res   <= s1_sp_res;
      s2_sp_flags <= s1_sp_flags;
    end
  end

  // ---------------- S3: normalise, round, pack ----------------
  logic                  carry, rnd_up;
  logic [LZW-1:0]        lzc;
  logic [AW-1:0]         norm;
  logic [MAN_W+1:0]      mant_r;
  logic signed [EW2-1:0] exp_norm, exp_fin;

  always_comb begin
    lzc = '0;
    for (int i = 0; i < AW; i++) begin
      if (s2_sum[i]) lzc = LZW'(AW - 1 - i);   // highest set bit wins
    end
    carry = s2_sum[SW-1];
    if (carry) begin
      norm     = {s2_sum[SW-1:2], s2_sum[1] | s2_sum[0]};
      exp_norm = EW2'(s2_exp) + EW2'(1);
    end else begin
      norm     = s2_sum[AW-1:0] << lzc;
      exp_norm = EW2'(s2_exp) - EW2'(lzc);
    end

    rnd_up  = norm[2] & (norm[1] | norm[0] | norm[3]);
    mant_r  = {1'b0, norm[AW-1:3]} + (MAN_W+2)'(rnd_up);
    exp_fin = exp_norm + EW2'(mant_r[MAN_W+1]);

    res_c   = {s2_sign, exp_fin[EXP_W-1:0],
               mant_r[MAN_W+1] ? mant_r[MAN_W:1] : mant_r[MAN_W-1:0]};
    flags_c = {3'b000, |norm[2:0]};

    if (s2_sp) begin
      res_c   = s2_sp_res;
      flags_c = s2_sp_flags;
    end else if (s2_sum == '0) begin
      res_c   = '0;                             // exact cancellation gives +0
      flags_c = '0;
    end else if (int'(exp_norm) <= 0) begin
      res_c   = {s2_sign, {(W-1){1'b0}}};
      flags_c = 4'b0011;
    end else if (int'(exp_fin) >= EXP_MAX) begin
      res_c   = {s2_sign, INF_MAG};
      flags_c = 4'b0101;
    end
  end
endmodule
